alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Sequencer for an 8-bit ALU: runs narrow (one pass) or wide (two chained passes) operations,
// plus mode instructions that only present an opcode; result and NVCZ flags are registered.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_out,
  input  logic        alu_carryout,
  input  logic        alu_over,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  flags
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StMode, StResp} state_e;

  state_e      state_q;
  logic [7:0]  op_q;
  logic        wide_q;
  logic [7:0]  a_hi_q;
  logic [7:0]  b_hi_q;
  logic [7:0]  res_lo_q;

  logic        is_mode_op;
  logic [15:0] wide_res;

  assign is_mode_op = (req_op >= 8'h40) && (req_op <= 8'h44);
  assign wide_res   = {alu_out, res_lo_q};

  // All ALU drive outputs are registered and loaded on the edge that enters the state using them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 8'h00;
      wide_q      <= 1'b0;
      a_hi_q      <= 8'h00;
      b_hi_q      <= 8'h00;
      res_lo_q    <= 8'h00;
      req_ready   <= 1'b1;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_cins    <= 8'h00;
      alu_oe      <= 1'b0;
      alu_carryin <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'h0000;
      flags       <= 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q      <= req_op;
            wide_q    <= req_wide;
            a_hi_q    <= req_a[15:8];
            b_hi_q    <= req_b[15:8];
            req_ready <= 1'b0;
            alu_cins  <= req_op;
            if (is_mode_op) begin
              state_q <= StMode;
            end else begin
              state_q     <= StLo;
              alu_a       <= req_a[7:0];
              alu_b       <= req_b[7:0];
              alu_oe      <= 1'b1;
              alu_carryin <= 1'b0;
            end
          end
        end

        StLo: begin
          res_lo_q <= alu_out;
          if (wide_q) begin
            state_q     <= StHi;
            alu_a       <= a_hi_q;
            alu_b       <= b_hi_q;
            alu_cins    <= op_q;
            // Low-pass carry feeds the high pass.
            alu_carryin <= alu_carryout;
          end else begin
            state_q     <= StResp;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_cins    <= 8'h00;
            alu_oe      <= 1'b0;
            alu_carryin <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= {8'h00, alu_out};
            flags       <= {alu_out[7], alu_over, alu_carryout, (alu_out == 8'h00)};
          end
        end

        StHi: begin
          state_q     <= StResp;
          alu_a       <= 8'h00;
          alu_b       <= 8'h00;
          alu_cins    <= 8'h00;
          alu_oe      <= 1'b0;
          alu_carryin <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_data    <= wide_res;
          flags       <= {alu_out[7], alu_over, alu_carryout, (wide_res == 16'h0000)};
        end

        StMode: begin
          // Mode ops produce a zero result and leave the flags untouched.
          state_q   <= StResp;
          res_lo_q  <= 8'h00;
          alu_cins  <= 8'h00;
          rsp_valid <= 1'b1;
          rsp_data  <= 16'h0000;
        end

        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          req_ready   <= 1'b1;
          rsp_valid   <= 1'b0;
          alu_a       <= 8'h00;
          alu_b       <= 8'h00;
          alu_cins    <= 8'h00;
          alu_oe      <= 1'b0;
          alu_carryin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl: an 8-bit ALU model answers the DUT, and a transaction-level
// 16-bit arithmetic model predicts every cycle's outputs for one per-cycle compare process.
module tb_alu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_cins;
  logic        alu_oe;
  logic        alu_carryin;
  logic [7:0]  alu_out;
  logic        alu_carryout;
  logic        alu_over;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  flags;

  alu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_wide    (req_wide),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cins    (alu_cins),
    .alu_oe      (alu_oe),
    .alu_carryin (alu_carryin),
    .alu_out     (alu_out),
    .alu_carryout(alu_carryout),
    .alu_over    (alu_over),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 8-bit ALU: 0x10 add with carry, 0x20 and, 0x21 or, 0x22 xor, else zero.
  logic [8:0] alu_sum;
  always_comb begin
    alu_out      = 8'h00;
    alu_carryout = 1'b0;
    alu_over     = 1'b0;
    alu_sum      = 9'h000;
    if (alu_oe) begin
      case (alu_cins)
        8'h10: begin
          alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carryin};
          alu_out      = alu_sum[7:0];
          alu_carryout = alu_sum[8];
          alu_over     = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
        end
        8'h20: alu_out = alu_a & alu_b;
        8'h21: alu_out = alu_a | alu_b;
        8'h22: alu_out = alu_a ^ alu_b;
        default: alu_out = 8'h00;
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam int PhIdle = 0, PhLo = 1, PhHi = 2, PhMode = 3, PhResp = 4;

  int          exp_ph = PhIdle;
  logic [15:0] exp_a = '0, exp_b = '0, exp_data = '0;
  logic [7:0]  exp_op = '0;
  logic        exp_cin = 1'b0;
  logic [3:0]  exp_flags = 4'h0;

  // Single compare process: every negedge, all outputs against the phase the model expects.
  always @(negedge clk) begin
    logic [25:0] bus;
    bus = {alu_a, alu_b, alu_cins, alu_oe, alu_carryin};
    check("flags", {28'h0, flags}, {28'h0, exp_flags});
    check("req_ready", {31'h0, req_ready}, {31'h0, exp_ph == PhIdle});
    check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_ph == PhResp});
    case (exp_ph)
      PhLo:   check("alu_bus_lo", {6'h0, bus}, {6'h0, exp_a[7:0], exp_b[7:0], exp_op, 2'b10});
      PhHi:   check("alu_bus_hi", {6'h0, bus},
                    {6'h0, exp_a[15:8], exp_b[15:8], exp_op, 1'b1, exp_cin});
      PhMode: check("alu_bus_mode", {6'h0, bus}, {6'h0, 16'h0000, exp_op, 2'b00});
      PhResp: begin
        check("alu_bus_resp", {6'h0, bus}, 32'h0);
        check("rsp_data", {16'h0, rsp_data}, {16'h0, exp_data});
      end
      default: check("alu_bus_idle", {6'h0, bus}, 32'h0);
    endcase
  end

  function automatic logic is_mode(input logic [7:0] op);
    return (op >= 8'h40) && (op <= 8'h44);
  endfunction

  // Whole-operation result in plain 16-bit (or 8-bit) arithmetic; returns {N,V,C,Z,result}.
  function automatic logic [19:0] model(input logic [7:0] op, input logic wide,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, v, n;
    int          w;
    w = wide ? 16 : 8;
    c = 1'b0;
    v = 1'b0;
    case (op)
      8'h10: begin
        if (wide) s = {1'b0, a} + {1'b0, b};
        else      s = {9'h000, a[7:0]} + {9'h000, b[7:0]};
        c = s[w];
        r = wide ? s[15:0] : {8'h00, s[7:0]};
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      8'h20:   r = a & b;
      8'h21:   r = a | b;
      8'h22:   r = a ^ b;
      default: r = 16'h0000;
    endcase
    if (!wide) r[15:8] = 8'h00;
    n = r[w-1];
    return {n, v, c, (r == 16'h0000), r};
  endfunction

  task automatic scramble();
    req_valid = 1'($urandom);
    req_op    = 8'($urandom);
    req_wide  = 1'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE at posedge+1; returns the response data, flags and high-pass carry-in seen.
  task automatic run_txn(input logic [7:0] op, input logic wide, input logic [15:0] a,
                         input logic [15:0] b, input int bp,
                         output logic [15:0] cap_data, output logic [3:0] cap_flags,
                         output logic cap_cin);
    logic [19:0] m;
    logic [8:0]  lo;
    m  = model(op, wide, a, b);
    lo = {1'b0, a[7:0]} + {1'b0, b[7:0]};
    cap_cin   = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_wide  = wide;
    req_a     = a;
    req_b     = b;
    step();
    scramble();
    exp_op = op;
    exp_a  = a;
    exp_b  = b;
    if (is_mode(op)) begin
      exp_ph = PhMode;
      step();
      scramble();
      exp_data = 16'h0000;
    end else begin
      exp_ph  = PhLo;
      exp_cin = 1'b0;
      step();
      scramble();
      if (wide) begin
        exp_ph  = PhHi;
        exp_cin = (op == 8'h10) ? lo[8] : 1'b0;
        cap_cin = alu_carryin;
        step();
        scramble();
      end
      exp_data  = m[15:0];
      exp_flags = m[19:16];
    end
    exp_ph    = PhResp;
    cap_data  = rsp_data;
    cap_flags = flags;
    for (int i = 0; i < bp; i++) begin
      step();
      scramble();
    end
    // Handshake completes with a fresh request already pending; it must not be taken yet.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    exp_ph    = PhIdle;
  endtask

  logic [7:0]  op_tab [10] = '{8'h10, 8'h10, 8'h20, 8'h21, 8'h22, 8'h40, 8'h42, 8'h44,
                               8'h3F, 8'h45};
  logic [15:0] d;
  logic [3:0]  f;
  logic        cin;

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    req_op    = 8'h00;
    req_wide  = 1'b0;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
    rst = 1'b0;
    step();

    run_txn(8'h10, 1'b0, 16'h00F0, 16'h0020, 0, d, f, cin);
    check("narrow_add_data", {16'h0, d}, 32'h0010);
    check("narrow_add_flags", {28'h0, f}, 32'b0010);

    run_txn(8'h10, 1'b1, 16'h01FF, 16'h0001, 1, d, f, cin);
    check("wide_chain_data", {16'h0, d}, 32'h0200);
    check("wide_chain_flags", {28'h0, f}, 32'b0000);
    check("wide_chain_hi_cin", {31'h0, cin}, 32'h1);

    run_txn(8'h10, 1'b0, 16'hAB7F, 16'hCD01, 0, d, f, cin);
    check("narrow_neg_data", {16'h0, d}, 32'h0080);
    check("narrow_neg_flags", {28'h0, f}, 32'b1100);

    run_txn(8'h10, 1'b1, 16'hFFFF, 16'h0001, 0, d, f, cin);
    check("wide_zero_data", {16'h0, d}, 32'h0000);
    check("wide_zero_flags", {28'h0, f}, 32'b0011);

    // Mode op with long backpressure: flags must survive, response held for 5 cycles.
    run_txn(8'h42, 1'b0, 16'h1234, 16'h5678, 5, d, f, cin);
    check("mode_data", {16'h0, d}, 32'h0000);
    check("mode_flags", {28'h0, flags}, 32'b0011);

    // Reset during the high pass of a wide op.
    req_valid = 1'b1;
    req_op    = 8'h10;
    req_wide  = 1'b1;
    req_a     = 16'h1111;
    req_b     = 16'h2222;
    exp_op    = 8'h10;
    exp_a     = 16'h1111;
    exp_b     = 16'h2222;
    step();
    req_valid = 1'b0;
    exp_ph    = PhLo;
    exp_cin   = 1'b0;
    step();
    exp_ph = PhHi;
    #1;
    rst = 1'b1;
    #1;
    check("abort_alu_oe", {31'h0, alu_oe}, 32'h0);
    check("abort_flags", {28'h0, flags}, 32'h0);
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    exp_ph    = PhIdle;
    exp_flags = 4'h0;
    step();
    rst = 1'b0;
    repeat (2) step();

    for (int t = 0; t < 60; t++) begin
      logic [7:0] op;
      op = op_tab[$urandom_range(0, 9)];
      run_txn(op, 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3), d, f, cin);
      repeat ($urandom_range(0, 2)) begin
        scramble();
        req_valid = 1'b0;
        step();
      end
    end

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
